// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared defaults and mode encodings for the pipelined
//               add/subtract datapath.
//               DEF_WIDTH  - default operand/result width
//               DEF_STAGES - default pipeline depth
//               OP_ADD     - sub_in value selecting addition
//               OP_SUB     - sub_in value selecting subtraction
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;
   localparam int   DEF_WIDTH  = 32;
   localparam int   DEF_STAGES = 4;
   localparam logic OP_ADD     = 1'b0;
   localparam logic OP_SUB     = 1'b1;
endpackage
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// ============================================================================
// Module      : adder_slice
// Description : SLICE-bit combinational ripple-carry adder used as one stage
//               of the pipelined add/subtract datapath.
// Ports       : i_a, i_b    - slice operands
//               i_cin       - carry into bit 0
//               o_sum       - slice sum
//               o_cout      - carry out of the slice MSB
//               o_msb_cin   - carry into the slice MSB (for overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module adder_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] i_a,
   input  logic [SLICE-1:0] i_b,
   input  logic             i_cin,
   output logic [SLICE-1:0] o_sum,
   output logic             o_cout,
   output logic             o_msb_cin
);
   logic [SLICE:0] w_carry;

   always_comb begin
      w_carry    = '0;
      o_sum      = '0;
      w_carry[0] = i_cin;
      for (int i = 0; i < SLICE; i++) begin
         o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
         w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
      end
   end

   assign o_cout    = w_carry[SLICE];
   assign o_msb_cin = w_carry[SLICE-1];
endmodule
`default_nettype wire

// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_add_sub
// Description : WIDTH-bit adder/subtractor split into STAGES ripple slices,
//               one slice per pipeline stage, with valid/ready handshaking.
// Ports       : clk_in    - clock, rising edge
//               rst_n_in  - asynchronous active-low reset
//               A_in/B_in - operands
//               C_in      - carry-in (add mode only)
//               sub_in    - 0 add, 1 subtract
//               valid_in  - operands valid       / ready_out - accepting
//               S_out     - sum/difference
//               C_out     - MSB carry-out (subtract: 1 = no borrow)
//               V_out     - signed overflow      / Z_out - result is zero
//               valid_out - result valid         / ready_in  - consumer ready
// Revision    : 1.0 - initial release
// ============================================================================
import adder_pkg::*;

module pipelined_add_sub #(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic             C_in,
   input  logic             sub_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic [WIDTH-1:0] S_out,
   output logic             C_out,
   output logic             V_out,
   output logic             Z_out,
   output logic             valid_out,
   input  logic             ready_in
);
   localparam int SLICE = WIDTH / STAGES;

   if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
      $error("pipelined_add_sub: WIDTH must be a non-zero multiple of STAGES");
   end

   // Stage-k inputs (from ports for k = 0, from stage k-1 registers otherwise)
   logic [WIDTH-1:0]  w_a_in    [STAGES];
   logic [WIDTH-1:0]  w_b_in    [STAGES];
   logic [WIDTH-1:0]  w_s_in    [STAGES];
   logic [WIDTH-1:0]  w_s_next  [STAGES];
   logic [SLICE-1:0]  w_sum     [STAGES];
   logic [STAGES-1:0] w_c_in;
   logic [STAGES-1:0] w_v_in;
   logic [STAGES-1:0] w_cout;
   logic [STAGES-1:0] w_msb_cin;
   logic              w_adv;

   // Stage registers
   logic [WIDTH-1:0]  r_a       [STAGES];
   logic [WIDTH-1:0]  r_b       [STAGES];
   logic [WIDTH-1:0]  r_s       [STAGES];
   logic [STAGES-1:0] r_carry;
   logic [STAGES-1:0] r_valid;
   logic              r_ovf;
   logic              r_zero;

   // The whole pipeline moves together; it only freezes when the output
   // holds a result the consumer has not taken.
   assign w_adv     = !r_valid[STAGES-1] || ready_in;
   assign ready_out = w_adv;

   always_comb begin
      // B is inverted once at entry so later stages never need the mode bit.
      w_a_in[0] = A_in;
      w_b_in[0] = (sub_in == OP_ADD) ? B_in : ~B_in;
      w_s_in[0] = '0;
      w_c_in    = '0;
      w_v_in    = '0;
      w_c_in[0] = (sub_in == OP_SUB) ? 1'b1 : C_in;
      w_v_in[0] = valid_in;
      for (int k = 1; k < STAGES; k++) begin
         w_a_in[k] = r_a[k-1];
         w_b_in[k] = r_b[k-1];
         w_s_in[k] = r_s[k-1];
         w_c_in[k] = r_carry[k-1];
         w_v_in[k] = r_valid[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_slice #(
         .SLICE     (SLICE)
      ) u_slice (
         .i_a       (w_a_in[k][k*SLICE +: SLICE]),
         .i_b       (w_b_in[k][k*SLICE +: SLICE]),
         .i_cin     (w_c_in[k]),
         .o_sum     (w_sum[k]),
         .o_cout    (w_cout[k]),
         .o_msb_cin (w_msb_cin[k])
      );
   end

   // Completed slices ride forward; stage k drops its slice into place.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         w_s_next[k]                  = w_s_in[k];
         w_s_next[k][k*SLICE +: SLICE] = w_sum[k];
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
         end
         r_carry <= '0;
         r_valid <= '0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= w_a_in[k];
            r_b[k] <= w_b_in[k];
            r_s[k] <= w_s_next[k];
         end
         r_carry <= w_cout;
         r_valid <= w_v_in;
         // Flags are formed from the final-stage adder outputs so they are
         // registered alongside the sum rather than decoded from S_out.
         r_ovf   <= w_cout[STAGES-1] ^ w_msb_cin[STAGES-1];
         r_zero  <= ~|w_s_next[STAGES-1];
      end
   end

   // Operand copies leaving the last stage and intermediate MSB carries have
   // no consumer; they are gathered here so they are visibly intentional.
   logic w_unused_bits;
   assign w_unused_bits = ^{r_a[STAGES-1], r_b[STAGES-1], w_msb_cin};

   assign S_out     = r_s[STAGES-1];
   assign C_out     = r_carry[STAGES-1];
   assign V_out     = r_ovf;
   assign Z_out     = r_zero;
   assign valid_out = r_valid[STAGES-1];
endmodule
`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
module tb_pipelined_add_sub;
   import adder_pkg::*;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        v;
      logic        z;
   } exp_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      logic        sub;
      exp_t        e;
   } vec_t;

   // Directed vectors with hand-derived expected results.
   localparam vec_t VECS [8] = '{
      '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0100, 1'b0, 1'b0, 1'b0}},
      '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}},
      '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}},
      '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}},
      '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}},
      '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, '{32'h0000_0004, 1'b0, 1'b0, 1'b0}},
      '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, '{32'h0000_0007, 1'b1, 1'b0, 1'b0}},
      '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}}
   };

   logic        clk_in;
   logic        rst_n_in;
   logic [31:0] A_in;
   logic [31:0] B_in;
   logic        C_in;
   logic        sub_in;
   logic        valid_in;
   logic        ready_in;

   logic        ready_out, C_out, V_out, Z_out, valid_out;
   logic [31:0] S_out;
   logic        s1_ready, s1_C, s1_V, s1_Z, s1_valid;
   logic [31:0] s1_S;
   logic        s8_ready, s8_C, s8_V, s8_Z, s8_valid;
   logic [31:0] s8_S;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb [$];

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .A_in(A_in), .B_in(B_in), .C_in(C_in),
      .sub_in(sub_in), .valid_in(valid_in), .ready_out(ready_out), .S_out(S_out),
      .C_out(C_out), .V_out(V_out), .Z_out(Z_out), .valid_out(valid_out),
      .ready_in(ready_in)
   );

   pipelined_add_sub #(.WIDTH(32), .STAGES(1)) dut_s1 (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .A_in(A_in), .B_in(B_in), .C_in(C_in),
      .sub_in(sub_in), .valid_in(valid_in), .ready_out(s1_ready), .S_out(s1_S),
      .C_out(s1_C), .V_out(s1_V), .Z_out(s1_Z), .valid_out(s1_valid),
      .ready_in(ready_in)
   );

   pipelined_add_sub #(.WIDTH(32), .STAGES(8)) dut_s8 (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .A_in(A_in), .B_in(B_in), .C_in(C_in),
      .sub_in(sub_in), .valid_in(valid_in), .ready_out(s8_ready), .S_out(s8_S),
      .C_out(s8_C), .V_out(s8_V), .Z_out(s8_Z), .valid_out(s8_valid),
      .ready_in(ready_in)
   );

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic c, input logic sub);
      logic [31:0] bb;
      logic [32:0] r;
      exp_t        e;
      bb  = (sub == OP_SUB) ? ~b : b;
      r   = {1'b0, a} + {1'b0, bb} + {32'd0, (sub == OP_SUB) ? 1'b1 : c};
      e.s = r[31:0];
      e.c = r[32];
      e.v = (a[31] == bb[31]) && (r[31] != a[31]);
      e.z = (r[31:0] == 32'd0);
      return e;
   endfunction

   // Scoreboard monitor for the STAGES=4 instance, plus stall stability.
   bit          prev_stall = 1'b0;
   logic [35:0] prev_out   = '0;
   always @(negedge clk_in) begin
      if (!rst_n_in) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_checks++;
            if ({S_out, C_out, V_out, Z_out, valid_out} !== prev_out) begin
               n_fail++;
               $display("FAIL stall_hold: got %h required %h",
                        {S_out, C_out, V_out, Z_out, valid_out}, prev_out);
            end
         end
         if (valid_out && !ready_in) begin
            n_checks++;
            if (ready_out !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_ready_out: got %b required 0", ready_out);
            end
         end
         if (valid_out && ready_in) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_result: got S=%h with no result outstanding", S_out);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if ({S_out, C_out, V_out, Z_out} !== e) begin
                  n_fail++;
                  $display("FAIL result: got S=%h C=%b V=%b Z=%b required S=%h C=%b V=%b Z=%b",
                           S_out, C_out, V_out, Z_out, e.s, e.c, e.v, e.z);
               end
            end
         end
         prev_stall = valid_out && !ready_in;
         prev_out   = {S_out, C_out, V_out, Z_out, valid_out};
      end
   end

   // Presents one operand set until the main instance accepts it.
   task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic sub, input exp_t e);
      bit ok = 1'b0;
      A_in = a; B_in = b; C_in = c; sub_in = sub; valid_in = 1'b1;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk_in);
         if (ready_out) begin
            sb.push_back(e);
            ok = 1'b1;
         end
         @(posedge clk_in); #1;
      end
      valid_in = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got ready_out=0 for 50 cycles required 1");
      end
   endtask

   task automatic test_reset();
      #3;
      n_checks++;
      if ({valid_out, S_out, C_out, V_out, Z_out} !== 36'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0", {valid_out, S_out, C_out, V_out, Z_out});
      end
      n_checks++;
      if ({s1_valid, s8_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_valid_sweep: got %b required 00", {s1_valid, s8_valid});
      end
      repeat (2) @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      #1;
      n_checks++;
      if ({ready_out, valid_out} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_release_ready: got ready/valid=%b required 10", {ready_out, valid_out});
      end
      @(posedge clk_in); #1;
   endtask

   // Directed vectors on all three depths, checking latency and values.
   task automatic test_add_cases();
      for (int i = 0; i < 8; i++) begin
         int          lat4 = 0, lat1 = 0, lat8 = 0;
         logic [34:0] got1 = '0, got8 = '0;
         send_op(VECS[i].a, VECS[i].b, VECS[i].c, VECS[i].sub, VECS[i].e);
         for (int cyc = 1; cyc <= 12; cyc++) begin
            if (valid_out && lat4 == 0) lat4 = cyc;
            if (s1_valid && lat1 == 0) begin lat1 = cyc; got1 = {s1_S, s1_C, s1_V, s1_Z}; end
            if (s8_valid && lat8 == 0) begin lat8 = cyc; got8 = {s8_S, s8_C, s8_V, s8_Z}; end
            if (lat4 != 0 && lat1 != 0 && lat8 != 0) break;
            @(posedge clk_in); #1;
         end
         n_checks++;
         if (lat4 != 4) begin
            n_fail++;
            $display("FAIL latency_s4 vec%0d: got %0d required 4", i, lat4);
         end
         n_checks++;
         if (lat1 != 1) begin
            n_fail++;
            $display("FAIL latency_s1 vec%0d: got %0d required 1", i, lat1);
         end
         n_checks++;
         if (lat8 != 8) begin
            n_fail++;
            $display("FAIL latency_s8 vec%0d: got %0d required 8", i, lat8);
         end
         n_checks++;
         if (got1 !== VECS[i].e) begin
            n_fail++;
            $display("FAIL result_s1 vec%0d: got %h required %h", i, got1, VECS[i].e);
         end
         n_checks++;
         if (got8 !== VECS[i].e) begin
            n_fail++;
            $display("FAIL result_s8 vec%0d: got %h required %h", i, got8, VECS[i].e);
         end
         @(posedge clk_in); #1;
      end
   endtask

   // Eight random transfers streamed back to back with a 3-cycle stall.
   task automatic test_back_to_back();
      int          sent = 0;
      bit          need_new = 1'b1;
      logic [31:0] a = '0, b = '0;
      logic        c = 1'b0, s = 1'b0;
      for (int cyc = 0; cyc < 100 && sent < 8; cyc++) begin
         ready_in = (cyc >= 5 && cyc < 8) ? 1'b0 : 1'b1;
         if (need_new) begin
            a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
         end
         A_in = a; B_in = b; C_in = c; sub_in = s; valid_in = 1'b1;
         @(negedge clk_in);
         need_new = ready_out;
         if (ready_out) begin
            sb.push_back(model(a, b, c, s));
            sent++;
         end
         @(posedge clk_in); #1;
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      for (int t = 0; t < 30 && sb.size() != 0; t++) begin
         @(posedge clk_in); #1;
      end
      n_checks++;
      if (sent != 8 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL back_to_back_drain: got sent=%0d outstanding=%0d required 8/0", sent, sb.size());
      end
      repeat (10) @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset_mid_op();
      int lat = 0;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] a, b;
         a = $urandom; b = $urandom;
         send_op(a, b, 1'b0, OP_ADD, model(a, b, 1'b0, OP_ADD));
      end
      @(posedge clk_in); #1;
      n_checks++;
      if (valid_out !== 1'b1) begin
         n_fail++;
         $display("FAIL inflight_before_reset: got valid_out=%b required 1", valid_out);
      end
      #1 rst_n_in = 1'b0;
      #1;
      n_checks++;
      if ({valid_out, S_out, C_out, V_out, Z_out} !== 36'd0) begin
         n_fail++;
         $display("FAIL async_reset_clear: got %h required 0", {valid_out, S_out, C_out, V_out, Z_out});
      end
      sb.delete();
      repeat (2) @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      #1;
      n_checks++;
      if (ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b required 1", ready_out);
      end
      for (int t = 0; t < 6; t++) begin
         @(negedge clk_in);
         n_checks++;
         if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_after_reset: got valid_out=%b required 0", valid_out);
         end
      end
      @(posedge clk_in); #1;
      send_op(32'h0000_0010, 32'h0000_0020, 1'b1, OP_ADD, '{32'h0000_0031, 1'b0, 1'b0, 1'b0});
      for (int cyc = 1; cyc <= 12 && lat == 0; cyc++) begin
         if (valid_out) lat = cyc;
         else begin @(posedge clk_in); #1; end
      end
      n_checks++;
      if (lat != 4) begin
         n_fail++;
         $display("FAIL latency_after_reset: got %0d required 4", lat);
      end
      repeat (3) @(posedge clk_in);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_in = 1'b0;
      A_in = '0; B_in = '0; C_in = 1'b0; sub_in = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      test_reset();
      test_add_cases();
      test_back_to_back();
      test_reset_mid_op();
      repeat (5) @(posedge clk_in);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL final_outstanding: got %0d required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
